// File: rtl/io_bank_hs_if.sv
// -----------------------------------------------------------------------------
// io_bank_hs_if
// Groups the processor-side and external-side signals of io_bank_hs.
//   slave  modport : the I/O bank itself
//   master modport : the processor plus external world driving the bank
// Signals:
//   proc_req_in / proc_addr_in / proc_data_in / proc_stall : input-read port
//   proc_out_en / proc_addr_out / proc_data_out            : output-write port
//   io_in / io_in_vld / io_in_ack / io_in_ovr               : external inputs
//   io_out / io_out_vld                                     : external outputs
//   timeout_err / err_chan                                  : stall timeout status
// -----------------------------------------------------------------------------
interface io_bank_hs_if #(
  parameter int NBITS  = 33,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4
);
  localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic                     proc_req_in;
  logic [AWI-1:0]           proc_addr_in;
  logic [NBITS-1:0]         proc_data_in;
  logic                     proc_stall;
  logic                     proc_out_en;
  logic [AWO-1:0]           proc_addr_out;
  logic [NBITS-1:0]         proc_data_out;
  logic [NUIOIN*NBITS-1:0]  io_in;
  logic [NUIOIN-1:0]        io_in_vld;
  logic [NUIOIN-1:0]        io_in_ack;
  logic [NUIOIN-1:0]        io_in_ovr;
  logic [NUIOOU*NBITS-1:0]  io_out;
  logic [NUIOOU-1:0]        io_out_vld;
  logic                     timeout_err;
  logic [AWI-1:0]           err_chan;

  modport slave (
    input  proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_data_out,
    input  io_in, io_in_vld,
    output proc_data_in, proc_stall, io_in_ack, io_in_ovr, io_out, io_out_vld,
    output timeout_err, err_chan
  );

  modport master (
    output proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_data_out,
    output io_in, io_in_vld,
    input  proc_data_in, proc_stall, io_in_ack, io_in_ovr, io_out, io_out_vld,
    input  timeout_err, err_chan
  );
endinterface

// File: rtl/io_bank_hs.sv
// -----------------------------------------------------------------------------
// io_bank_hs
// Handshaked I/O bank between the processor and external ports.
//   - one capture buffer per input channel, filled on io_in_vld, emptied when
//     the processor reads it (io_in_ack pulses the cycle after)
//   - a held register per output channel, written on proc_out_en
//     (io_out_vld pulses the cycle after)
//   - reads of an empty buffer stall the processor; after TMOUT stall cycles
//     one TOUT cycle releases the stall and records a sticky timeout error
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : io_bank_hs_if.slave, all processor and external signals
// -----------------------------------------------------------------------------
module io_bank_hs #(
  parameter int NBITS  = 33,
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int TMOUT  = 255
) (
  input logic         clk,
  input logic         rst,
  io_bank_hs_if.slave bus
);
  localparam int AWI = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int AWO = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int CW  = (TMOUT > 1) ? $clog2(TMOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TOUT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [NBITS-1:0]  buf_q [NUIOIN];
  logic [NBITS-1:0]  buf_d [NUIOIN];
  logic [NUIOIN-1:0] full_q, full_d;
  logic [NUIOIN-1:0] ovr_q, ovr_d;
  logic [NUIOIN-1:0] ack_q, ack_d;
  logic [NUIOIN-1:0] cons_vec;
  logic [NBITS-1:0]  out_q [NUIOOU];
  logic [NBITS-1:0]  out_d [NUIOOU];
  logic [NUIOOU-1:0] ovld_q, ovld_d;
  logic              tout_q, tout_d;
  logic [AWI-1:0]    echan_q, echan_d;
  logic              rd_hit, rd_full, stall, consume;
  logic [NBITS-1:0]  rd_word;

  // Read-address decode as an AND-OR mux; out-of-range addresses match nothing.
  always_comb begin
    rd_hit  = 1'b0;
    rd_full = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      rd_hit  = rd_hit  | (bus.proc_addr_in == AWI'(i));
      rd_full = rd_full | ((bus.proc_addr_in == AWI'(i)) & full_q[i]);
      rd_word = rd_word | ({NBITS{bus.proc_addr_in == AWI'(i)}} & buf_q[i]);
    end
  end

  // The TOUT cycle neither stalls nor consumes, which releases the processor.
  assign stall   = bus.proc_req_in & rd_hit & ~rd_full & (state_q != S_TOUT);
  assign consume = bus.proc_req_in & rd_full & (state_q != S_TOUT);

  assign bus.proc_stall   = stall;
  assign bus.proc_data_in = consume ? rd_word : '0;
  assign bus.io_in_ack    = ack_q;
  assign bus.io_in_ovr    = ovr_q;
  assign bus.io_out_vld   = ovld_q;
  assign bus.timeout_err  = tout_q;
  assign bus.err_chan     = echan_q;

  // Pack the held output registers onto the flat external bus.
  always_comb begin
    bus.io_out = '0;
    for (int j = 0; j < NUIOOU; j++) begin
      bus.io_out[j*NBITS +: NBITS] = out_q[j];
    end
  end

  // Per-channel capture: a consume and a new word on the same edge refill the
  // buffer without counting as an overrun.
  always_comb begin
    for (int i = 0; i < NUIOIN; i++) begin
      cons_vec[i] = consume & (bus.proc_addr_in == AWI'(i));
      full_d[i]   = full_q[i];
      buf_d[i]    = buf_q[i];
      ovr_d[i]    = ovr_q[i];
      if (cons_vec[i]) begin
        full_d[i] = bus.io_in_vld[i];
        if (bus.io_in_vld[i]) begin
          buf_d[i] = bus.io_in[i*NBITS +: NBITS];
        end else begin
          buf_d[i] = buf_q[i];
        end
      end else if (bus.io_in_vld[i] && !full_q[i]) begin
        buf_d[i]  = bus.io_in[i*NBITS +: NBITS];
        full_d[i] = 1'b1;
      end else if (bus.io_in_vld[i]) begin
        ovr_d[i] = 1'b1;
      end else begin
        ovr_d[i] = ovr_q[i];
      end
    end
    ack_d = cons_vec;
  end

  // Output write path; an out-of-range address matches no channel.
  always_comb begin
    for (int j = 0; j < NUIOOU; j++) begin
      ovld_d[j] = bus.proc_out_en & (bus.proc_addr_out == AWO'(j));
      out_d[j]  = ovld_d[j] ? bus.proc_data_out : out_q[j];
    end
  end

  // Stall FSM: cnt counts consecutive stall cycles; reaching TMOUT enters TOUT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    echan_d = echan_q;
    cnt_inc = (state_q == S_WAIT) ? cnt_q + CW'(1) : CW'(1);
    case (state_q)
      S_IDLE, S_WAIT: begin
        if (stall) begin
          cnt_d = cnt_inc;
          if ((TMOUT != 0) && (cnt_inc == CW'(TMOUT))) begin
            state_d = S_TOUT;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_TOUT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tout_d  = 1'b1;
        echan_d = bus.proc_addr_in;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      full_q  <= '0;
      ovr_q   <= '0;
      ack_q   <= '0;
      ovld_q  <= '0;
      tout_q  <= 1'b0;
      echan_q <= '0;
      for (int i = 0; i < NUIOIN; i++) buf_q[i] <= '0;
      for (int j = 0; j < NUIOOU; j++) out_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      ack_q   <= ack_d;
      ovld_q  <= ovld_d;
      tout_q  <= tout_d;
      echan_q <= echan_d;
      for (int i = 0; i < NUIOIN; i++) buf_q[i] <= buf_d[i];
      for (int j = 0; j < NUIOOU; j++) out_q[j] <= out_d[j];
    end
  end
endmodule

// File: tb/tb_io_bank_hs.sv
// -----------------------------------------------------------------------------
// tb_io_bank_hs
// Self-checking bench for io_bank_hs (4 in / 4 out channels, 33-bit words,
// timeout after 8 stall cycles): a per-cycle vector table, hand-written
// stall/timeout/reset sequences, then random traffic against a reference model.
// -----------------------------------------------------------------------------
module tb_io_bank_hs;
  localparam int NB = 33;
  localparam int TM = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  io_bank_hs_if #(.NBITS(NB), .NUIOIN(4), .NUIOOU(4)) bus ();

  io_bank_hs #(.NBITS(NB), .NUIOIN(4), .NUIOOU(4), .TMOUT(TM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          req;
    logic [1:0]    addr;
    logic [3:0]    vld;
    logic [NB-1:0] word;
    logic          oen;
    logic [1:0]    oaddr;
    logic [NB-1:0] odata;
    logic          e_stall;
    logic [NB-1:0] e_data;
    logic [3:0]    e_ack;
    logic [3:0]    e_ovld;
    logic [3:0]    e_ovr;
  } vec_t;

  vec_t tbl [14];

  // reference model state
  logic [NB-1:0] m_buf [4];
  logic [NB-1:0] m_out [4];
  logic [3:0]    m_full, m_ovr, m_ack, m_ovld;
  int            m_run;
  logic          m_tout, m_to;
  logic [1:0]    m_ec;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [1:0] addr, input logic [3:0] vld,
                       input logic [NB-1:0] word, input logic oen, input logic [1:0] oaddr,
                       input logic [NB-1:0] odata);
    bus.proc_req_in   = req;
    bus.proc_addr_in  = addr;
    bus.io_in_vld     = vld;
    bus.io_in         = {4{word}};
    bus.proc_out_en   = oen;
    bus.proc_addr_out = oaddr;
    bus.proc_data_out = odata;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, bus.proc_stall, 0);
    chk({tag, " data"}, bus.proc_data_in, 0);
    chk({tag, " ack"}, bus.io_in_ack, 0);
    chk({tag, " ovld"}, bus.io_out_vld, 0);
    chk({tag, " ovr"}, bus.io_in_ovr, 0);
    chk({tag, " tout"}, bus.timeout_err, 0);
    chk({tag, " echan"}, bus.err_chan, 0);
    chk({tag, " io_out"}, bus.io_out, 0);
  endtask

  // Hold a read request on addr until the stall drops (bounded); returns the
  // number of stall cycles and the data seen on the first non-stall cycle.
  task automatic stall_run(input logic [1:0] addr, input int vld_at, input logic [NB-1:0] w,
                           output int n, output logic [NB-1:0] dat);
    n   = 0;
    dat = '1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      drive(1'b1, addr, (k == vld_at) ? (4'b0001 << addr) : 4'b0000, w, 1'b0, 2'd0, '0);
      @(negedge clk);
      if (bus.proc_stall) begin
        n++;
      end else begin
        dat = bus.proc_data_in;
        break;
      end
    end
  endtask

  initial begin
    int            n;
    logic [NB-1:0] dat;
    logic          r_req;
    logic [1:0]    r_addr;
    logic [3:0]    r_vld;
    logic [NB-1:0] r_word, r_od, e_data;
    logic          r_oen, e_stall, cons, stl;
    logic [1:0]    r_oa;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(1'b0, 2'd0, 4'd0, '0, 1'b0, 2'd0, '0);

    //            req  addr  vld      word            oen  oa    odata         stall data            ack      ovld     ovr
    tbl[0]  = '{1'b0, 2'd0, 4'b0100, 33'h012340005, 1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b1, 2'd2, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h012340005,  4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0100, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b1, 2'd1, 33'h1AAAA,   1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b1, 2'd3, 33'h15555,   1'b0, 33'h0,          4'b0000, 4'b0010, 4'b0000};
    tbl[5]  = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b1000, 4'b0000};
    tbl[6]  = '{1'b0, 2'd0, 4'b0001, 33'h0000000A1, 1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 2'd0, 4'b0001, 33'h0000000B2, 1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b1, 2'd0, 4'b0001, 33'h10000000C, 1'b0, 2'd0, 33'h0,       1'b0, 33'h0000000A1,  4'b0000, 4'b0000, 4'b0001};
    tbl[9]  = '{1'b1, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h10000000C,  4'b0001, 4'b0000, 4'b0001};
    tbl[10] = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0001, 4'b0000, 4'b0001};
    tbl[11] = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0001};
    tbl[12] = '{1'b1, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b1, 33'h0,          4'b0000, 4'b0000, 4'b0001};
    tbl[13] = '{1'b0, 2'd0, 4'b0000, 33'h0,         1'b0, 2'd0, 33'h0,       1'b0, 33'h0,          4'b0000, 4'b0000, 4'b0001};

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // vector table, one row per cycle
    for (int r = 0; r < 14; r++) begin
      @(posedge clk); #1;
      drive(tbl[r].req, tbl[r].addr, tbl[r].vld, tbl[r].word, tbl[r].oen, tbl[r].oaddr, tbl[r].odata);
      @(negedge clk);
      chk($sformatf("row%0d stall", r), bus.proc_stall, tbl[r].e_stall);
      chk($sformatf("row%0d data", r), bus.proc_data_in, tbl[r].e_data);
      chk($sformatf("row%0d ack", r), bus.io_in_ack, tbl[r].e_ack);
      chk($sformatf("row%0d ovld", r), bus.io_out_vld, tbl[r].e_ovld);
      chk($sformatf("row%0d ovr", r), bus.io_in_ovr, tbl[r].e_ovr);
    end
    chk("held ch0", bus.io_out[0*NB +: NB], 33'h0);
    chk("held ch1", bus.io_out[1*NB +: NB], 33'h1AAAA);
    chk("held ch2", bus.io_out[2*NB +: NB], 33'h0);
    chk("held ch3", bus.io_out[3*NB +: NB], 33'h15555);

    // empty read on ch1, word arrives after 5 stall cycles
    stall_run(2'd1, 5, 33'h0DEAD0001, n, dat);
    chk("wait stall cycles", n, 6);
    chk("wait data", dat, 33'h0DEAD0001);
    chk("wait no timeout", bus.timeout_err, 0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 4'd0, '0, 1'b0, 2'd0, '0);
    @(negedge clk);
    chk("wait ack", bus.io_in_ack, 4'b0010);

    // empty read on ch3 never satisfied -> timeout
    stall_run(2'd3, -1, '0, n, dat);
    chk("tout stall cycles", n, TM);
    chk("tout data", dat, 0);
    chk("tout flag before", bus.timeout_err, 0);
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 4'd0, '0, 1'b0, 2'd0, '0);
    @(negedge clk);
    chk("tout flag", bus.timeout_err, 1);
    chk("tout chan", bus.err_chan, 3);
    chk("tout no ack", bus.io_in_ack, 0);

    // reset in the middle of a wait
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 2'd2, 4'd0, '0, 1'b0, 2'd0, '0);
    end
    @(negedge clk);
    chk("midwait stall", bus.proc_stall, 1);
    #2;
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'd0, '0, 1'b0, 2'd0, '0);
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    stall_run(2'd3, -1, '0, n, dat);
    chk("postreset stall cycles", n, TM);
    chk("postreset data", dat, 0);

    // random traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'd0, '0, 1'b0, 2'd0, '0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = '0;
      m_out[i] = '0;
    end
    m_full = '0; m_ovr = '0; m_ack = '0; m_ovld = '0;
    m_run = 0; m_tout = 1'b0; m_to = 1'b0; m_ec = 2'd0;
    r_req = 1'b0;
    r_addr = 2'd0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if ($urandom_range(5, 0) == 0) begin
        r_req  = ($urandom_range(2, 0) != 0);
        r_addr = 2'($urandom_range(3, 0));
      end
      for (int i = 0; i < 4; i++) r_vld[i] = ($urandom_range(9, 0) == 0);
      r_word = {1'($urandom_range(1, 0)), 32'($urandom)};
      r_oen  = ($urandom_range(2, 0) == 0);
      r_oa   = 2'($urandom_range(3, 0));
      r_od   = {1'($urandom_range(1, 0)), 32'($urandom)};
      drive(r_req, r_addr, r_vld, r_word, r_oen, r_oa, r_od);

      cons    = r_req && m_full[r_addr] && !m_tout;
      stl     = r_req && !m_full[r_addr] && !m_tout;
      e_stall = stl;
      e_data  = cons ? m_buf[r_addr] : '0;

      @(negedge clk);
      chk($sformatf("rnd%0d stall", cyc), bus.proc_stall, e_stall);
      chk($sformatf("rnd%0d data", cyc), bus.proc_data_in, e_data);
      chk($sformatf("rnd%0d ack", cyc), bus.io_in_ack, m_ack);
      chk($sformatf("rnd%0d ovld", cyc), bus.io_out_vld, m_ovld);
      chk($sformatf("rnd%0d ovr", cyc), bus.io_in_ovr, m_ovr);
      chk($sformatf("rnd%0d tout", cyc), bus.timeout_err, m_to);
      chk($sformatf("rnd%0d echan", cyc), bus.err_chan, m_ec);
      chk($sformatf("rnd%0d io_out", cyc), bus.io_out, {m_out[3], m_out[2], m_out[1], m_out[0]});

      // advance the model by one clock edge
      if (m_tout) begin
        m_to   = 1'b1;
        m_ec   = r_addr;
        m_tout = 1'b0;
        m_run  = 0;
      end else if (stl) begin
        m_run++;
        if (m_run == TM) begin
          m_tout = 1'b1;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      for (int i = 0; i < 4; i++) begin
        if (cons && (r_addr == 2'(i))) begin
          m_full[i] = r_vld[i];
          if (r_vld[i]) m_buf[i] = r_word;
        end else if (r_vld[i]) begin
          if (!m_full[i]) begin
            m_buf[i]  = r_word;
            m_full[i] = 1'b1;
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
      end
      m_ack  = cons ? (4'b0001 << r_addr) : 4'b0000;
      m_ovld = r_oen ? (4'b0001 << r_oa) : 4'b0000;
      if (r_oen) m_out[r_oa] = r_od;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/io_bank_hs.md
Name: io_bank_hs

Overview:
- Parametrised, handshaked successor to the bare address-decoder I/O glue that sits between proc_fl and its external ports.
- Per-channel input capture buffers with valid/ack handshake, per-channel held output registers with write strobes, and processor stall on empty-input reads.
- Stall is bounded by a timeout counter; a timeout raises a sticky error.
- Sits between the processor I/O signals and the external world; any int/float conversion stays outside this block.

Parameters:
- NBITS, 33, data word width (matches the 16+16+1 float word).
- NUIOIN, 4, number of input channels.
- NUIOOU, 4, number of output channels.
- TMOUT, 255, stall cycles before timeout; 0 = never time out.
- Derived (localparam, not overridable): AWI = max(1, clog2(NUIOIN)), AWO = max(1, clog2(NUIOOU)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- proc_req_in  in  1  processor input-read request.
- proc_addr_in  in  AWI  input channel selected for read.
- proc_data_in  out  NBITS  data returned to processor.
- proc_stall  out  1  processor must hold its request and wait.
- proc_out_en  in  1  processor output-write strobe.
- proc_addr_out  in  AWO  output channel selected for write.
- proc_data_out  in  NBITS  data written by processor.
- io_in  in  NUIOIN*NBITS  external input words, channel i at bits [i*NBITS +: NBITS].
- io_in_vld  in  NUIOIN  external word valid, per channel.
- io_in_ack  out  NUIOIN  one-cycle pulse: buffered word consumed.
- io_in_ovr  out  NUIOIN  sticky overrun flag, per channel.
- io_out  out  NUIOOU*NBITS  held output words.
- io_out_vld  out  NUIOOU  one-cycle write pulse, per channel.
- timeout_err  out  1  sticky timeout flag.
- err_chan  out  AWI  channel that caused the last timeout.

Behaviour:
- Reset (asynchronous, any time including mid-wait):
  - All buffers, full flags, io_out, io_out_vld, io_in_ack, io_in_ovr, timeout_err, err_chan and wait counter go to 0; FSM goes to IDLE.
  - An in-progress wait is aborted.
- Input capture, per channel i:
  - If io_in_vld[i]=1 and full[i]=0: buf[i] <= word, full[i] <= 1.
  - If io_in_vld[i]=1 and full[i]=1 (not consumed this cycle): keep old word, set io_in_ovr[i] (sticky until reset).
- Read path:
  - proc_data_in is combinational: buf[proc_addr_in] when proc_req_in=1 and full[addr]=1; otherwise 0.
  - Consume: a cycle with proc_req_in=1 and full[a]=1 clears full[a] at the edge. io_in_ack[a] is registered and pulses high the following cycle.
  - Consume and a new io_in_vld[a] on the same edge: the new word is captured, full[a] stays 1, no overrun.
  - Word arriving in the same cycle as the request into an empty buffer: that cycle stalls; the word is readable the next cycle.
- Stall FSM:
  - States: IDLE, WAIT, TOUT.
  - proc_stall = proc_req_in & ~full[addr] & (state != TOUT) & addr in range.
  - IDLE -> WAIT on the first stall cycle, counter <= 1.
  - WAIT: counter increments per stall cycle.
  - WAIT -> IDLE when full[addr] rises, or when proc_req_in drops (request dropped; counter cleared).
  - WAIT -> TOUT when counter == TMOUT and TMOUT != 0.
  - TOUT lasts one cycle: stall = 0, proc_data_in = 0, no consume, timeout_err <= 1, err_chan <= addr. Then -> IDLE.
  - TMOUT = 0: stall is unbounded.
- Write path:
  - On proc_out_en: io_out[proc_addr_out] <= proc_data_out; io_out_vld[addr] pulses high for exactly the next cycle.
  - Other channels hold their values. Back-to-back writes to the same channel give consecutive vld pulses.
- Out-of-range addresses (addr >= NUIOIN or >= NUIOOU):
  - Read returns 0 with no stall and no state change.
  - Write is ignored.
- Reads and writes are independent and may occur in the same cycle.

Test Plan:
- Reset, then io_in_vld[2]=1 with word 0x0_1234_0005 for 1 cycle; then read addr 2 -> proc_data_in=0x0_1234_0005 same cycle, stall=0, io_in_ack[2] pulses next cycle, full[2] clears.
- Read addr 1 with buffer empty, word arrives after 5 cycles -> proc_stall high exactly 5 cycles + arrival cycle, then data returned, timeout_err stays 0.
- TMOUT=8, read empty addr 3, never supply data -> stall for 8 cycles, then one TOUT cycle with stall=0 and data=0; timeout_err=1, err_chan=3.
- Two vld pulses on ch0 without a read -> first word retained, io_in_ovr[0]=1. Consume and new vld on the same edge -> new word buffered, ovr unchanged.
- Write 0x1AAAA to ch1 then 0x15555 to ch3 on consecutive cycles -> io_out_vld pulses 0010 then 1000; io_out ch1=0x1AAAA held; other channels 0.
- Assert rst mid-WAIT (counter=4) -> proc_stall=0, all outputs 0, FSM IDLE; a subsequent read behaves as after power-up.
